// File: rtl/count_link_pkg.sv
// Shared types and helpers for the count link serial transmitter.
// Holds the frame FSM state enum, line levels and a frame length helper.
package count_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Total busy cycles of one frame: start + data + optional parity + stops.
    function automatic int frame_cycles(
        input int data_w,
        input int clks_per_bit,
        input int stop_bits,
        input bit parity
    );
        return (1 + data_w + int'(parity) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/count_baud_tick.sv
// Bit-period counter for the count link transmitter.
// Ports: clk, rst (async, active-high), clear_i (frame start),
//        run_i (frame in progress), bit_end_o (last cycle of a bit period).
module count_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic bit_end_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end_o = run_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = '0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_frame_tx.sv
// Async-frame serial transmitter: start bit, data LSB first, stop bit(s).
// Ports: clk, rst (async, active-high), ena (gates acceptance),
//        data_in/valid/ready (word handshake), tx (serial line, idles high),
//        busy (frame in progress), frame_done (last cycle of last stop bit).
// Option: define COUNT_FRAME_TX_PARITY_EN to append an even parity bit.
module count_frame_tx
    import count_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
`ifdef COUNT_FRAME_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              tx_q;
    logic              tx_d;
    logic              bit_end;
    logic              accept;
`ifdef COUNT_FRAME_TX_PARITY_EN
    logic              par_q;
    logic              par_d;
`endif

    assign ready  = ena && (state_q == IDLE) && !rst;
    assign accept = valid && ready;
    assign busy   = (state_q != IDLE);
    assign tx     = tx_q;

    count_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept),
        .run_i    (busy),
        .bit_end_o(bit_end)
    );

    // idx counts data bits in DATA and is reused to count stop bits.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        frame_done = 1'b0;
`ifdef COUNT_FRAME_TX_PARITY_EN
        par_d      = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    sh_d    = data_in;
                    idx_d   = '0;
                    tx_d    = START_LVL;
`ifdef COUNT_FRAME_TX_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d = '0;
`ifdef COUNT_FRAME_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = LINE_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
`ifdef COUNT_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            tx_q    <= LINE_IDLE;
`ifdef COUNT_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
`ifdef COUNT_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Busy-cycle count of the current frame, checked when it ends.
    int len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= 0;
        end else begin
            if (frame_done) begin
                assert (len_q + 1 ==
                        frame_cycles(DATA_W, CLKS_PER_BIT, STOP_BITS, PAR_EN));
            end
            if (accept) begin
                len_q <= 0;
            end else if (busy) begin
                len_q <= len_q + 1;
            end
        end
    end

endmodule

// File: tb/tb_count_frame_tx.sv
// Self-checking bench for count_frame_tx: vector table, corner sequences
// and random words against a per-cycle line model.
module tb_count_frame_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef COUNT_FRAME_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [DW-1:0] data_in;
    logic          valid;
    logic          ready;
    logic          tx;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    bit expq[$];

    always #5 clk = ~clk;

    count_frame_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .data_in   (data_in),
        .valid     (valid),
        .ready     (ready),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected line level for every busy cycle of a frame carrying w.
    task automatic build_model(input logic [DW-1:0] w);
        bit lv[$];
        int ones;
        expq.delete();
        ones = 0;
        lv.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            lv.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (PAR) lv.push_back(bit'(ones % 2));
        for (int i = 0; i < SB; i++) lv.push_back(1'b1);
        foreach (lv[k])
            for (int j = 0; j < CPB; j++) expq.push_back(lv[k]);
    endtask

    // Called at a negedge with the DUT idle; returns at the idle negedge
    // right after frame_done. Mid-bit line samples are returned in mids.
    task automatic run_frame(input logic [DW-1:0] w, input bit hold,
                             input bit drop_ena, output logic [15:0] mids);
        int nbusy;
        mids = '0;
        nbusy = 0;
        build_model(w);
        data_in = w;
        valid = 1'b1;
        #1;
        chk("ready_pre", {31'b0, ready}, {31'b0, ena});
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
        data_in = DW'($urandom);
        for (int c = 0; c < expq.size(); c++) begin
            @(negedge clk);
            if (drop_ena && c == 9) ena = 1'b0;
            chk($sformatf("tx_c%0d", c), {31'b0, tx}, {31'b0, expq[c]});
            chk("busy_in", {31'b0, busy}, 32'd1);
            chk("done", {31'b0, frame_done}, {31'b0, c == expq.size() - 1});
            if (busy) nbusy++;
            if (c % CPB == CPB / 2) mids[c / CPB] = tx;
        end
        busy_total += nbusy;
        chk("frame_len", nbusy,
            count_link_pkg::frame_cycles(DW, CPB, SB, PAR));
        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_tx", {31'b0, tx}, 32'd1);
        chk("idle_done", {31'b0, frame_done}, 32'd0);
        chk("idle_ready", {31'b0, ready}, {31'b0, ena});
    endtask

    function automatic logic [15:0] exp_mids(input vec_t v);
        if (PAR) return {5'b0, 1'b1, v.par, v.line[8:0]};
        return {6'b0, v.line};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int gap;
        vecs[0] = '{8'hA5, 10'h34A, 1'b0};
        vecs[1] = '{8'h07, 10'h20E, 1'b1};
        vecs[2] = '{8'h03, 10'h206, 1'b0};
        vecs[3] = '{8'h3C, 10'h278, 1'b0};
        vecs[4] = '{8'h00, 10'h200, 1'b0};
        vecs[5] = '{8'h80, 10'h300, 1'b1};

        rst = 1'b1;
        ena = 1'b1;
        valid = 1'b0;
        data_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", {31'b0, tx}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_ready", {31'b0, ready}, 32'd0);
            chk("rst_done", {31'b0, frame_done}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        chk("post_rst_tx", {31'b0, tx}, 32'd1);

        foreach (vecs[i]) begin
            run_frame(vecs[i].data, 1'b0, 1'b0, m);
            chk($sformatf("mids_%0h", vecs[i].data), m, exp_mids(vecs[i]));
        end

        busy_total = 0;
        run_frame(8'h01, 1'b1, 1'b0, m);
        chk("b2b_first", m, exp_mids('{8'h01, 10'h202, 1'b1}));
        run_frame(8'hFF, 1'b0, 1'b0, m);
        chk("b2b_second", m, exp_mids('{8'hFF, 10'h3FE, 1'b0}));
        chk("b2b_busy", busy_total,
            2 * count_link_pkg::frame_cycles(DW, CPB, SB, PAR));

        run_frame(8'hC3, 1'b0, 1'b1, m);
        chk("ena_frame", m, exp_mids('{8'hC3, 10'h386, 1'b0}));
        valid = 1'b1;
        data_in = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ena0_ready", {31'b0, ready}, 32'd0);
            chk("ena0_tx", {31'b0, tx}, 32'd1);
            chk("ena0_busy", {31'b0, busy}, 32'd0);
        end
        valid = 1'b0;
        ena = 1'b1;
        @(negedge clk);

        data_in = 8'h5A;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        data_in = 8'hFF;
        repeat (15) @(negedge clk);
        chk("mid_tx_low", {31'b0, tx}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'b0, tx}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'b0, ready}, 32'd1);
        run_frame(8'h3C, 1'b0, 1'b0, m);
        chk("after_rst", m, exp_mids(vecs[3]));

        for (int r = 0; r < 20; r++) begin
            logic [DW-1:0] w;
            bit h;
            w = DW'($urandom);
            h = bit'($urandom_range(0, 1));
            run_frame(w, h, 1'b0, m);
            if (!h) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_tx", {31'b0, tx}, 32'd1);
                    chk("gap_busy", {31'b0, busy}, 32'd0);
                end
            end
        end
        valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
